// File: rtl/subsample_mixer_pkg.sv
// Shared definitions for the subsample mixer: register map, config struct, shift clamp helper.
package subsample_mixer_pkg;

  localparam logic [15:0] MIXER_REG_CONTROL = 16'hF000;
  localparam logic [15:0] MIXER_REG_SHIFT   = 16'hF001;
  localparam logic [15:0] MIXER_REG_MUTE_LO = 16'hF002;
  localparam logic [15:0] MIXER_REG_MUTE_HI = 16'hF003;

  localparam int unsigned CTRL_ENABLE_BIT = 0;
  localparam int unsigned CTRL_CLEAR_BIT  = 1;

  typedef struct packed {
    logic        Enable;
    logic [4:0]  Shift;
    logic [31:0] MuteMask;
  } MixerConfig_t;

  function automatic logic [4:0] clamp_shift(input logic [4:0] value,
                                             input int unsigned max_shift);
    if (32'(value) > max_shift) return 5'(max_shift);
    return value;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through sample queue; data_o holds the last popped word while empty.
module sample_fifo #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic [Width-1:0] last_q, last_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (PtrW+1)'(Depth));
  assign empty_o = (count_q == '0);

  assign pop_ok  = pop_i & ~empty_o;
  // A push into a full queue still succeeds when a pop frees a slot in the same cycle.
  assign push_ok = push_i & (~full_o | pop_ok);

  assign data_o = empty_o ? last_q : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
      last_d   = mem_q[rd_ptr_q];
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PtrW+1)'(1);
      2'b01:   count_d = count_q - (PtrW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/subsample_mixer.sv
// Per-voice subsample accumulator with mute, programmable shift and output FIFO.
// Optional output saturation with sticky o_Clipped: define OCTANE_MIXER_SATURATION_EN.
module subsample_mixer
  import subsample_mixer_pkg::*;
#(
  parameter int unsigned SUBSAMPLE_WIDTH = 16,
  parameter int unsigned NUM_VOICES      = 16,
  parameter int unsigned SAMPLE_WIDTH    = 16,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                       i_Clock,
  input  logic                       i_Reset_n,
  input  logic [SUBSAMPLE_WIDTH-1:0] i_Subsample,
  input  logic                       i_SubsampleValid,
  input  logic [4:0]                 i_SubsampleVoice,
  input  logic                       i_FrameEnd,
  input  logic [15:0]                i_RegisterNumber,
  input  logic [15:0]                i_RegisterValue,
  input  logic                       i_RegisterWriteEnable,
  output logic [SAMPLE_WIDTH-1:0]    o_Sample,
  output logic                       o_SampleValid,
  input  logic                       i_SampleReady,
  output logic                       o_FrameDropped,
  output logic                       o_Clipped
);

  localparam int unsigned VoiceBits = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 0;
  localparam int unsigned ACC_WIDTH = SUBSAMPLE_WIDTH + VoiceBits;
  localparam int unsigned MAX_SHIFT = ACC_WIDTH - 1;

  MixerConfig_t cfg_q, cfg_d;
  logic         clear_sticky;

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0] term, acc_sum;
  logic signed [ACC_WIDTH-1:0] frame_sum_q, frame_sum_d;
  logic [4:0]                  frame_shift_q, frame_shift_d;
  logic                        frame_vld_q, frame_vld_d;
  logic                        voice_in_range, take, frame_end;

  logic [SAMPLE_WIDTH-1:0] sample;
  logic                    fifo_full, fifo_empty, fifo_pop;
  logic                    dropped_q, dropped_d;

  // Register bus decode
  always_comb begin
    cfg_d        = cfg_q;
    clear_sticky = 1'b0;
    if (i_RegisterWriteEnable) begin
      case (i_RegisterNumber)
        MIXER_REG_CONTROL: begin
          cfg_d.Enable = i_RegisterValue[CTRL_ENABLE_BIT];
          clear_sticky = i_RegisterValue[CTRL_CLEAR_BIT];
        end
        MIXER_REG_SHIFT:   cfg_d.Shift = clamp_shift(i_RegisterValue[4:0], MAX_SHIFT);
        MIXER_REG_MUTE_LO: cfg_d.MuteMask[15:0] = i_RegisterValue;
        MIXER_REG_MUTE_HI: cfg_d.MuteMask[31:16] = i_RegisterValue;
        default: ;
      endcase
    end
  end

  assign voice_in_range = (32'(i_SubsampleVoice) < NUM_VOICES);
  assign take = i_SubsampleValid & cfg_q.Enable & voice_in_range
              & ~cfg_q.MuteMask[i_SubsampleVoice];
  assign term      = take ? ACC_WIDTH'($signed(i_Subsample)) : '0;
  assign acc_sum   = acc_q + term;
  assign frame_end = i_SubsampleValid & i_FrameEnd & cfg_q.Enable;

  // Stage 1: accumulate; on frame end capture the sum and the shift in force this cycle.
  always_comb begin
    acc_d         = acc_q;
    frame_vld_d   = 1'b0;
    frame_sum_d   = frame_sum_q;
    frame_shift_d = frame_shift_q;
    if (!cfg_q.Enable) begin
      acc_d = '0;
    end else if (frame_end) begin
      acc_d         = '0;
      frame_vld_d   = 1'b1;
      frame_sum_d   = acc_sum;
      frame_shift_d = cfg_q.Shift;
    end else if (i_SubsampleValid) begin
      acc_d = acc_sum;
    end
  end

  // Stage 2: scale and narrow, feeding the FIFO push.
`ifdef OCTANE_MIXER_SATURATION_EN
  localparam int unsigned ExtW = (ACC_WIDTH > SAMPLE_WIDTH) ? ACC_WIDTH : SAMPLE_WIDTH;
  localparam logic signed [ExtW-1:0] SatMax = ExtW'({1'b0, {(SAMPLE_WIDTH-1){1'b1}}});
  localparam logic signed [ExtW-1:0] SatMin = ~SatMax;

  logic signed [ExtW-1:0] shifted_ext;
  logic                   clip_hi, clip_lo;
  logic                   clipped_q, clipped_d;

  assign shifted_ext = ExtW'(frame_sum_q >>> frame_shift_q);
  assign clip_hi     = (shifted_ext > SatMax);
  assign clip_lo     = (shifted_ext < SatMin);

  always_comb begin
    sample = shifted_ext[SAMPLE_WIDTH-1:0];
    if (clip_hi) sample = SatMax[SAMPLE_WIDTH-1:0];
    else if (clip_lo) sample = SatMin[SAMPLE_WIDTH-1:0];
    clipped_d = (frame_vld_q & (clip_hi | clip_lo)) | (clipped_q & ~clear_sticky);
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) clipped_q <= 1'b0;
    else            clipped_q <= clipped_d;
  end

  assign o_Clipped = clipped_q;
`else
  assign sample    = SAMPLE_WIDTH'(frame_sum_q >>> frame_shift_q);
  assign o_Clipped = 1'b0;
`endif

  assign fifo_pop = ~fifo_empty & i_SampleReady;

  // Set wins over a same-cycle clear.
  assign dropped_d = (frame_vld_q & fifo_full & ~fifo_pop) | (dropped_q & ~clear_sticky);

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      cfg_q.Enable   <= 1'b1;
      cfg_q.Shift    <= 5'(VoiceBits);
      cfg_q.MuteMask <= '0;
      acc_q          <= '0;
      frame_sum_q    <= '0;
      frame_shift_q  <= '0;
      frame_vld_q    <= 1'b0;
      dropped_q      <= 1'b0;
    end else begin
      cfg_q          <= cfg_d;
      acc_q          <= acc_d;
      frame_sum_q    <= frame_sum_d;
      frame_shift_q  <= frame_shift_d;
      frame_vld_q    <= frame_vld_d;
      dropped_q      <= dropped_d;
    end
  end

  sample_fifo #(
    .Width (SAMPLE_WIDTH),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_Clock),
    .rst_ni  (i_Reset_n),
    .push_i  (frame_vld_q),
    .data_i  (sample),
    .pop_i   (fifo_pop),
    .data_o  (o_Sample),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign o_SampleValid  = ~fifo_empty;
  assign o_FrameDropped = dropped_q;

endmodule

// File: tb/tb_subsample_mixer.sv
// Directed-plus-random bench for subsample_mixer with a frame-level reference model.
module tb_subsample_mixer;

  localparam int NV    = 16;
  localparam int DEPTH = 4;
  localparam int MAXSH = 19;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] sub;
  logic        sub_vld;
  logic [4:0]  sub_voice;
  logic        frame_end;
  logic [15:0] reg_num;
  logic [15:0] reg_val;
  logic        reg_we;
  logic [15:0] sample;
  logic        sample_vld;
  logic        sample_rdy;
  logic        dropped;
  logic        clipped;

  always #5 clk = ~clk;

  subsample_mixer dut (
    .i_Clock               (clk),
    .i_Reset_n             (rst_n),
    .i_Subsample           (sub),
    .i_SubsampleValid      (sub_vld),
    .i_SubsampleVoice      (sub_voice),
    .i_FrameEnd            (frame_end),
    .i_RegisterNumber      (reg_num),
    .i_RegisterValue       (reg_val),
    .i_RegisterWriteEnable (reg_we),
    .o_Sample              (sample),
    .o_SampleValid         (sample_vld),
    .i_SampleReady         (sample_rdy),
    .o_FrameDropped        (dropped),
    .o_Clipped             (clipped)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state
  int          shift_m;
  logic [31:0] mute_m;
  logic        en_m;
  logic        drop_m;
  logic        clip_m;
  logic [15:0] exp_q[$];
  logic [15:0] last_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    shift_m = 4;
    mute_m  = '0;
    en_m    = 1'b1;
    drop_m  = 1'b0;
    clip_m  = 1'b0;
    last_m  = '0;
    exp_q.delete();
  endtask

  function automatic logic [15:0] model_frame(input int vals[NV]);
    longint sum = 0;
    for (int v = 0; v < NV; v++) if (!mute_m[v]) sum += vals[v];
    sum = sum >>> shift_m;
`ifdef OCTANE_MIXER_SATURATION_EN
    if (sum > 32767) begin clip_m = 1'b1; return 16'h7FFF; end
    if (sum < -32768) begin clip_m = 1'b1; return 16'h8000; end
`endif
    return sum[15:0];
  endfunction

  task automatic write_reg(input logic [15:0] addr, input logic [15:0] val);
    @(negedge clk);
    reg_num = addr;
    reg_val = val;
    reg_we  = 1'b1;
    @(negedge clk);
    reg_we  = 1'b0;
    case (addr)
      16'hF000: begin
        en_m = val[0];
        if (val[1]) begin drop_m = 1'b0; clip_m = 1'b0; end
      end
      16'hF001: shift_m = (int'(val[4:0]) > MAXSH) ? MAXSH : int'(val[4:0]);
      16'hF002: mute_m[15:0] = val;
      16'hF003: mute_m[31:16] = val;
      default: ;
    endcase
  endtask

  // Returns in the middle of the cycle after the frame-end subsample.
  task automatic send_frame(input int vals[NV]);
    logic [15:0] s;
    for (int v = 0; v < NV; v++) begin
      @(negedge clk);
      sub_vld   = 1'b1;
      sub_voice = 5'(v);
      sub       = 16'(vals[v]);
      frame_end = (v == NV - 1);
    end
    @(negedge clk);
    sub_vld   = 1'b0;
    frame_end = 1'b0;
    if (en_m) begin
      s = model_frame(vals);
      if (exp_q.size() < DEPTH) exp_q.push_back(s);
      else drop_m = 1'b1;
    end
  endtask

  task automatic drain();
    logic [15:0] e;
    for (int i = 0; i < DEPTH + 2 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check("valid", 32'(sample_vld), 32'd1);
      check("sample", 32'(sample), 32'(e));
      last_m = e;
      sample_rdy = 1'b1;
      @(posedge clk);
      #1 sample_rdy = 1'b0;
    end
    @(negedge clk);
    check("empty", 32'(sample_vld), 32'd0);
    check("hold", 32'(sample), 32'(last_m));
    check("dropped", 32'(dropped), 32'(drop_m));
    check("clipped", 32'(clipped), 32'(clip_m));
  endtask

  task automatic rand_vals(output int vals[NV]);
    logic [15:0] r;
    for (int v = 0; v < NV; v++) begin
      r = 16'($urandom);
      vals[v] = int'($signed(r));
    end
  endtask

  int vals[NV];

  initial begin
    rst_n = 1'b0; sub = '0; sub_vld = 1'b0; sub_voice = '0; frame_end = 1'b0;
    reg_num = '0; reg_val = '0; reg_we = 1'b0; sample_rdy = 1'b0;
    model_reset();
    #3;
    check("rst_valid", 32'(sample_vld), 32'd0);
    check("rst_sample", 32'(sample), 32'd0);
    check("rst_dropped", 32'(dropped), 32'd0);
    check("rst_clipped", 32'(clipped), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Equal voices, default shift, two-cycle latency
    foreach (vals[v]) vals[v] = 32'h0100;
    send_frame(vals);
    check("lat_n1", 32'(sample_vld), 32'd0);
    @(negedge clk);
    check("lat_n2", 32'(sample_vld), 32'd1);
    check("lat_sample", 32'(sample), 32'h0100);
    drain();

    // Only voice 0 unmuted
    write_reg(16'hF002, 16'hFFFE);
    foreach (vals[v]) vals[v] = 32'h7FFF;
    send_frame(vals);
    drain();
    write_reg(16'hF002, 16'h0000);

    // Shift 0 overflows the output width
    write_reg(16'hF001, 16'h0000);
    send_frame(vals);
    drain();
    write_reg(16'hF000, 16'h0003);

    // Shift write above the maximum clamps
    write_reg(16'hF001, 16'h001F);
    rand_vals(vals);
    send_frame(vals);
    drain();
    write_reg(16'hF001, 16'h0004);

    // Out-of-range voice and FrameEnd without valid are both ignored
    @(negedge clk);
    sub_vld = 1'b1; sub_voice = 5'd20; sub = 16'h4000; frame_end = 1'b0;
    @(negedge clk);
    sub_vld = 1'b0; frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
    rand_vals(vals);
    send_frame(vals);
    drain();

    // Disabled mixer produces no frame
    write_reg(16'hF000, 16'h0000);
    rand_vals(vals);
    send_frame(vals);
    repeat (3) @(negedge clk);
    check("disabled", 32'(sample_vld), 32'd0);
    write_reg(16'hF000, 16'h0001);
    rand_vals(vals);
    send_frame(vals);
    drain();

    // Overflow the queue with random config per frame
    for (int f = 0; f < DEPTH + 1; f++) begin
      write_reg(16'hF002, 16'($urandom));
      write_reg(16'hF001, 16'($urandom_range(0, MAXSH)));
      rand_vals(vals);
      send_frame(vals);
    end
    repeat (2) @(negedge clk);
    check("drop_set", 32'(dropped), 32'(drop_m));
    write_reg(16'hF000, 16'h0003);
    check("drop_clr", 32'(dropped), 32'd0);
    drain();
    write_reg(16'hF002, 16'h0000);
    write_reg(16'hF001, 16'h0004);

    // Push coincident with pop on a full queue
    for (int f = 0; f < DEPTH; f++) begin
      rand_vals(vals);
      send_frame(vals);
    end
    @(negedge clk);
    check("full_head", 32'(sample), 32'(exp_q[0]));
    last_m = exp_q.pop_front();
    rand_vals(vals);
    send_frame(vals);
    sample_rdy = 1'b1;
    @(posedge clk);
    #1 sample_rdy = 1'b0;
    @(negedge clk);
    check("coinc_nodrop", 32'(dropped), 32'd0);
    drain();

    // Async reset mid-frame discards everything
    write_reg(16'hF001, 16'h0002);
    rand_vals(vals);
    send_frame(vals);
    for (int v = 0; v < 7; v++) begin
      @(negedge clk);
      sub_vld = 1'b1; sub_voice = 5'(v); sub = 16'h1000; frame_end = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_valid", 32'(sample_vld), 32'd0);
    check("mid_rst_sample", 32'(sample), 32'd0);
    check("mid_rst_dropped", 32'(dropped), 32'd0);
    @(negedge clk);
    sub_vld = 1'b0;
    rst_n = 1'b1;
    foreach (vals[v]) vals[v] = 32'h0010;
    send_frame(vals);
    drain();

    // Random frames with random mute and shift
    for (int f = 0; f < 6; f++) begin
      write_reg(16'hF002, 16'($urandom));
      write_reg(16'hF001, 16'($urandom_range(0, MAXSH)));
      rand_vals(vals);
      send_frame(vals);
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
